// File: rtl/contador_bcd_2dig.sv
// ============================================================================
// Module   : contador_bcd_2dig
// Brief    : Two-digit BCD up/down counter with prescaler, parallel load and
//            wrap flag; feeds the units/tens 7-segment decoders.
// Revision : 1.0
// ============================================================================
`default_nettype none

module contador_bcd_2dig #(
   parameter int PRESCALE = 50_000_000,
   parameter int PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       up,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [3:0] unidade,
   output logic [3:0] dezena,
   output logic       tick,
   output logic       carry,
   output logic       err
);

   localparam logic [PS_W-1:0] c_ps_last = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0] r_ps;
   logic [3:0]      r_uni;
   logic [3:0]      r_dez;
   logic            r_tick;
   logic            r_carry;
   logic            r_err;

   logic            w_step;
   logic            w_load_ok;
   logic [3:0]      w_uni_nxt;
   logic [3:0]      w_dez_nxt;
   logic            w_wrap;

   assign w_step    = en && (r_ps == c_ps_last);
   assign w_load_ok = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);

   // Next digit pair for one step; only ever produces digits in 0..9.
   always_comb begin
      w_uni_nxt = r_uni;
      w_dez_nxt = r_dez;
      w_wrap    = 1'b0;
      if (up) begin
         if (r_uni >= 4'd9) begin
            w_uni_nxt = 4'd0;
            if (r_dez >= 4'd9) begin
               w_dez_nxt = 4'd0;
               w_wrap    = 1'b1;
            end else begin
               w_dez_nxt = r_dez + 4'd1;
            end
         end else begin
            w_uni_nxt = r_uni + 4'd1;
         end
      end else begin
         if (r_uni == 4'd0) begin
            w_uni_nxt = 4'd9;
            if (r_dez == 4'd0) begin
               w_dez_nxt = 4'd9;
               w_wrap    = 1'b1;
            end else begin
               w_dez_nxt = r_dez - 4'd1;
            end
         end else begin
            w_uni_nxt = r_uni - 4'd1;
         end
      end
   end

   // Load outranks a step; a rejected load also freezes the prescaler.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ps    <= '0;
         r_uni   <= 4'd0;
         r_dez   <= 4'd0;
         r_tick  <= 1'b0;
         r_carry <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_tick  <= 1'b0;
         r_carry <= 1'b0;
         if (load) begin
            if (w_load_ok) begin
               r_uni <= load_val[3:0];
               r_dez <= load_val[7:4];
               r_ps  <= '0;
               r_err <= 1'b0;
            end else begin
               r_err <= 1'b1;
            end
         end else if (w_step) begin
            r_ps    <= '0;
            r_uni   <= w_uni_nxt;
            r_dez   <= w_dez_nxt;
            r_tick  <= 1'b1;
            r_carry <= w_wrap;
         end else if (en) begin
            r_ps <= r_ps + PS_W'(1);
         end
      end
   end

   assign unidade = r_uni;
   assign dezena  = r_dez;
   assign tick    = r_tick;
   assign carry   = r_carry;
   assign err     = r_err;

endmodule

`default_nettype wire
